// File: rtl/traffic_pkg.sv
// Shared types for the traffic light monitor: lamp phases, error codes,
// FSM states and the legal phase-order helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_RED        = 2'd0,
        PH_RED_ORANGE = 2'd1,
        PH_GREEN      = 2'd2,
        PH_ORANGE     = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ILLEGAL_ENC = 3'd1,
        ERR_BAD_ORDER   = 3'd2,
        ERR_DWELL_SHORT = 3'd3,
        ERR_DWELL_LONG  = 3'd4
    } err_code_t;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_TRACK  = 1'b1
    } mon_state_t;

    // The only legal successor of each phase: RED -> RO -> GREEN -> ORANGE -> RED.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:        next_phase = PH_RED_ORANGE;
            PH_RED_ORANGE: next_phase = PH_GREEN;
            PH_GREEN:      next_phase = PH_ORANGE;
            default:       next_phase = PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational lamp decoder: maps {red,orange,green} onto a phase and
// flags whether the lamp combination is one of the four legal encodings.
module traffic_phase_decode
    import traffic_pkg::*;
(
    input  logic   red,
    input  logic   orange,
    input  logic   green,
    output phase_t phase,
    output logic   legal
);

    // Table lookup; illegal combinations report RED so phase is never X.
    always_comb begin
        phase = PH_RED;
        legal = 1'b0;
        case ({red, orange, green})
            3'b100: begin phase = PH_RED;        legal = 1'b1; end
            3'b110: begin phase = PH_RED_ORANGE; legal = 1'b1; end
            3'b001: begin phase = PH_GREEN;      legal = 1'b1; end
            3'b010: begin phase = PH_ORANGE;     legal = 1'b1; end
            default: begin phase = PH_RED;       legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: synchronises to the lamp sequence on the first RED,
// then checks phase order and per-phase dwell times, latching the first
// error and counting complete legal light cycles.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int RED_DELAY        = 4,
    parameter int RED_ORANGE_DELAY = 1,
    parameter int GREEN_DELAY      = 6,
    parameter int ORANGE_DELAY     = 1,
    parameter int COUNTER_WIDTH    = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       red,
    input  logic       orange,
    input  logic       green,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       err,
    output logic [2:0] err_code,
    output logic       cycle_done,
    output logic [7:0] cycle_count
);

    localparam logic [COUNTER_WIDTH-1:0] DWELL_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] DWELL_ONE = COUNTER_WIDTH'(1);

    mon_state_t                state_reg;
    phase_t                    phase_reg;
    logic                      phase_valid_reg;
    logic                      err_reg;
    err_code_t                 err_code_reg;
    logic                      cycle_done_reg;
    logic [7:0]                cycle_count_reg;
    logic [COUNTER_WIDTH-1:0]  dwell_cnt_reg;
    // Set once RED has been entered from a checked ORANGE; until then the
    // RED dwell after sync is unchecked and the cycle does not count.
    logic                      cycle_ok_reg;

    phase_t                    in_phase;
    logic                      in_legal;
    logic [COUNTER_WIDTH-1:0]  cur_delay;
    logic                      dwell_checked;
    logic                      is_same;
    logic                      is_succ;
    err_code_t                 err_detect;

    traffic_phase_decode u_decode (
        .red    (red),
        .orange (orange),
        .green  (green),
        .phase  (in_phase),
        .legal  (in_legal)
    );

    // Required dwell for each phase.
    function automatic logic [COUNTER_WIDTH-1:0] delay_of(input phase_t p);
        case (p)
            PH_RED:        delay_of = COUNTER_WIDTH'(RED_DELAY);
            PH_RED_ORANGE: delay_of = COUNTER_WIDTH'(RED_ORANGE_DELAY);
            PH_GREEN:      delay_of = COUNTER_WIDTH'(GREEN_DELAY);
            default:       delay_of = COUNTER_WIDTH'(ORANGE_DELAY);
        endcase
    endfunction

    // Classify the sampled lamps against the tracked phase; illegal encodings win.
    always_comb begin
        cur_delay     = delay_of(phase_reg);
        dwell_checked = cycle_ok_reg || (phase_reg != PH_RED);
        is_same       = in_legal && (in_phase == phase_reg);
        is_succ       = in_legal && (in_phase == next_phase(phase_reg));
        err_detect    = ERR_NONE;
        if (!in_legal) begin
            err_detect = ERR_ILLEGAL_ENC;
        end else if (is_same) begin
            if (dwell_checked && (dwell_cnt_reg >= cur_delay))
                err_detect = ERR_DWELL_LONG;
        end else if (is_succ) begin
            if (dwell_checked && (dwell_cnt_reg != cur_delay))
                err_detect = ERR_DWELL_SHORT;
        end else begin
            err_detect = ERR_BAD_ORDER;
        end
    end

    // Monitor FSM with dwell counter, sticky error capture and cycle counting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_UNSYNC;
            phase_reg       <= PH_RED;
            phase_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= ERR_NONE;
            cycle_done_reg  <= 1'b0;
            cycle_count_reg <= 8'd0;
            dwell_cnt_reg   <= '0;
            cycle_ok_reg    <= 1'b0;
        end else begin
            cycle_done_reg <= 1'b0;
            case (state_reg)
                ST_UNSYNC: begin
                    // Wait for the first RED; anything else, illegal or not, is ignored.
                    if (in_legal && (in_phase == PH_RED)) begin
                        state_reg       <= ST_TRACK;
                        phase_reg       <= PH_RED;
                        phase_valid_reg <= 1'b1;
                        dwell_cnt_reg   <= DWELL_ONE;
                        cycle_ok_reg    <= 1'b0;
                    end
                end
                default: begin
                    if (err_detect != ERR_NONE) begin
                        err_reg <= 1'b1;
                        if (!err_reg)
                            err_code_reg <= err_detect;
                        state_reg       <= ST_UNSYNC;
                        phase_valid_reg <= 1'b0;
                        dwell_cnt_reg   <= '0;
                        cycle_ok_reg    <= 1'b0;
                    end else if (is_same) begin
                        // Saturate only matters for the unchecked RED after sync.
                        if (dwell_cnt_reg != DWELL_MAX)
                            dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
                    end else if (is_succ) begin
                        phase_reg     <= next_phase(phase_reg);
                        dwell_cnt_reg <= DWELL_ONE;
                        if (phase_reg == PH_ORANGE) begin
                            if (cycle_ok_reg) begin
                                cycle_done_reg  <= 1'b1;
                                cycle_count_reg <= cycle_count_reg + 8'd1;
                            end
                            cycle_ok_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;
    assign cycle_done  = cycle_done_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a vector table for the legal
// three-cycle run plus hand-written error, wrap and reset sequences.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_RO  = 3'b110;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_O   = 3'b010;

    typedef struct packed {
        logic [2:0] lamps;
        logic [1:0] phase;
        logic       pv;
        logic       err;
        logic [2:0] code;
        logic       done;
        logic [7:0] count;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       red = 1'b0, orange = 1'b0, green = 1'b0;
    logic [1:0] phase;
    logic       phase_valid, err, cycle_done;
    logic [2:0] err_code;
    logic [7:0] cycle_count;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    traffic_light_monitor dut (
        .clk         (clk),
        .rstn        (rstn),
        .red         (red),
        .orange      (orange),
        .green       (green),
        .phase       (phase),
        .phase_valid (phase_valid),
        .err         (err),
        .err_code    (err_code),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [2:0] l, input logic [1:0] ph, input logic pv,
                                input logic e, input logic [2:0] c, input logic d,
                                input logic [7:0] cnt);
        vec_t v;
        v.lamps = l; v.phase = ph; v.pv = pv; v.err = e;
        v.code = c; v.done = d; v.count = cnt;
        return v;
    endfunction

    // Compare every output against one expected record; one line per vector.
    task automatic expect_out(input string tag, input vec_t x, input bit verbose);
        n_vec++;
        if (phase !== x.phase) begin
            $display("FAIL %s.phase got %0d want %0d", tag, phase, x.phase);
            n_miss++;
        end
        if (phase_valid !== x.pv) begin
            $display("FAIL %s.phase_valid got %b want %b", tag, phase_valid, x.pv);
            n_miss++;
        end
        if (err !== x.err) begin
            $display("FAIL %s.err got %b want %b", tag, err, x.err);
            n_miss++;
        end
        if (err_code !== x.code) begin
            $display("FAIL %s.err_code got %0d want %0d", tag, err_code, x.code);
            n_miss++;
        end
        if (cycle_done !== x.done) begin
            $display("FAIL %s.cycle_done got %b want %b", tag, cycle_done, x.done);
            n_miss++;
        end
        if (cycle_count !== x.count) begin
            $display("FAIL %s.cycle_count got %0d want %0d", tag, cycle_count, x.count);
            n_miss++;
        end
        if (verbose)
            $display("vec %0d %s lamps=%b phase=%0d pv=%b err=%b code=%0d done=%b count=%0d",
                     n_vec, tag, x.lamps, phase, phase_valid, err, err_code, cycle_done, cycle_count);
    endtask

    // Apply lamps away from the active edge, then sample 1 time unit after it.
    task automatic drive(input logic [2:0] lamps);
        @(negedge clk);
        {red, orange, green} = lamps;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input vec_t x);
        drive(x.lamps);
        expect_out(tag, x, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn = 1'b0;
        {red, orange, green} = 3'b000;
        #1;
        expect_out(tag, mk(3'b000, 2'd0, 0, 0, 3'd0, 0, 8'd0), 1'b1);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One legal cycle starting after ORANGE, with no error expected.
    task automatic legal_tail_quiet();
        drive(L_RO);
        for (int i = 0; i < 6; i++) drive(L_G);
        drive(L_O);
    endtask

    initial begin
        // ---- legal three-cycle run as a vector table ----
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++)
                tbl.push_back(mk(L_RED, 2'd0, 1, 0, 3'd0,
                                 (r == 2 && i == 0), (r == 2) ? 8'd1 : 8'd0));
            tbl.push_back(mk(L_RO, 2'd1, 1, 0, 3'd0, 0, (r == 2) ? 8'd1 : 8'd0));
            for (int i = 0; i < 6; i++)
                tbl.push_back(mk(L_G, 2'd2, 1, 0, 3'd0, 0, (r == 2) ? 8'd1 : 8'd0));
            tbl.push_back(mk(L_O, 2'd3, 1, 0, 3'd0, 0, (r == 2) ? 8'd1 : 8'd0));
        end
        tbl.push_back(mk(L_RED, 2'd0, 1, 0, 3'd0, 1, 8'd2));
        tbl.push_back(mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd2));

        rstn = 1'b0;
        #12;
        expect_out("por", mk(3'b000, 2'd0, 0, 0, 3'd0, 0, 8'd0), 1'b1);
        @(negedge clk);
        rstn = 1'b1;

        // Illegal encoding while unsynchronised is ignored.
        step("unsync_111", mk(3'b111, 2'd0, 0, 0, 3'd0, 0, 8'd0));
        step("unsync_green", mk(L_G, 2'd0, 0, 0, 3'd0, 0, 8'd0));

        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("legal[%0d]", k), tbl[k]);

        // ---- GREEN held too long ----
        do_reset("rst_long");
        step("long_sync", mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));
        step("long_ro", mk(L_RO, 2'd1, 1, 0, 3'd0, 0, 8'd0));
        for (int i = 0; i < 6; i++)
            step($sformatf("long_g%0d", i + 1), mk(L_G, 2'd2, 1, 0, 3'd0, 0, 8'd0));
        step("long_g7", mk(L_G, 2'd2, 0, 1, 3'd4, 0, 8'd0));

        // ---- checked RED too short, then first error sticks ----
        do_reset("rst_short");
        step("short_sync", mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));
        drive(L_RO); drive(L_G); drive(L_G); drive(L_G); drive(L_G); drive(L_G); drive(L_G);
        step("short_o", mk(L_O, 2'd3, 1, 0, 3'd0, 0, 8'd0));
        for (int i = 0; i < 3; i++)
            step($sformatf("short_r%0d", i + 1), mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));
        step("short_ro", mk(L_RO, 2'd0, 0, 1, 3'd3, 0, 8'd0));
        step("short_111", mk(3'b111, 2'd0, 0, 1, 3'd3, 0, 8'd0));
        step("short_resync", mk(L_RED, 2'd0, 1, 1, 3'd3, 0, 8'd0));
        step("short_badord", mk(L_G, 2'd0, 0, 1, 3'd3, 0, 8'd0));

        // ---- RED then GREEN skips RED_ORANGE ----
        do_reset("rst_order");
        for (int i = 0; i < 4; i++)
            step($sformatf("order_r%0d", i + 1), mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));
        step("order_g", mk(L_G, 2'd0, 0, 1, 3'd2, 0, 8'd0));

        // ---- illegal encoding while tracking, then resync ----
        do_reset("rst_illegal");
        step("ill_sync", mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));
        step("ill_000", mk(3'b000, 2'd0, 0, 1, 3'd1, 0, 8'd0));
        step("ill_resync", mk(L_RED, 2'd0, 1, 1, 3'd1, 0, 8'd0));

        // ---- 257 ORANGE->RED entries: 256 counted cycles wrap the counter ----
        do_reset("rst_wrap");
        for (int i = 0; i < 4; i++) drive(L_RED);
        for (int k = 1; k <= 257; k++) begin
            legal_tail_quiet();
            drive(L_RED);
            if (k == 1 || k == 2 || k == 255 || k == 256 || k == 257)
                expect_out($sformatf("wrap_entry%0d", k),
                           mk(L_RED, 2'd0, 1, 0, 3'd0, (k >= 2), 8'((k - 1) % 256)), 1'b1);
            else
                expect_out($sformatf("wrap_entry%0d", k),
                           mk(L_RED, 2'd0, 1, 0, 3'd0, (k >= 2), 8'((k - 1) % 256)), 1'b0);
            for (int i = 0; i < 3; i++) drive(L_RED);
        end
        step("wrap_ro", mk(L_RO, 2'd1, 1, 0, 3'd0, 0, 8'd0));
        step("wrap_g1", mk(L_G, 2'd2, 1, 0, 3'd0, 0, 8'd0));
        step("wrap_g2", mk(L_G, 2'd2, 1, 0, 3'd0, 0, 8'd0));

        // ---- asynchronous reset between edges, mid-GREEN, after an error ----
        step("pre_rst_err", mk(L_RO, 2'd2, 0, 1, 3'd2, 0, 8'd0));
        step("pre_rst_sync", mk(L_RED, 2'd0, 1, 1, 3'd2, 0, 8'd0));
        step("pre_rst_ro", mk(L_RO, 2'd1, 1, 1, 3'd2, 0, 8'd0));
        step("pre_rst_g", mk(L_G, 2'd2, 1, 1, 3'd2, 0, 8'd0));
        #2;
        rstn = 1'b0;
        #1;
        expect_out("async_rst", mk(L_G, 2'd0, 0, 0, 3'd0, 0, 8'd0), 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        step("post_rst_g", mk(L_G, 2'd0, 0, 0, 3'd0, 0, 8'd0));
        step("post_rst_sync", mk(L_RED, 2'd0, 1, 0, 3'd0, 0, 8'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The module SHALL have parameter RED_DELAY, default 4, meaning the required RED dwell in clk cycles.
REQ-002 The module SHALL have parameter RED_ORANGE_DELAY, default 1, meaning the required RED_ORANGE dwell in clk cycles.
REQ-003 The module SHALL have parameter GREEN_DELAY, default 6, meaning the required GREEN dwell in clk cycles.
REQ-004 The module SHALL have parameter ORANGE_DELAY, default 1, meaning the required ORANGE dwell in clk cycles.
REQ-005 The module SHALL have parameter COUNTER_WIDTH, default 3, meaning the dwell-counter width; every DELAY SHALL be 1..2^COUNTER_WIDTH-1.
REQ-006 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The module SHALL have port rstn, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-008 The module SHALL have ports red, orange and green, each input, 1 bit, the monitored lamps, synchronous to clk.
REQ-009 The module SHALL have port phase, output, 2 bits, the tracked phase_t.
REQ-010 The module SHALL have port phase_valid, output, 1 bit, high while the monitor is synchronised.
REQ-011 The module SHALL have port err, output, 1 bit, a sticky error flag.
REQ-012 The module SHALL have port err_code, output, 3 bits, the first error recorded since reset.
REQ-013 The module SHALL have port cycle_done, output, 1 bit, a one-cycle pulse for each complete legal light cycle.
REQ-014 The module SHALL have port cycle_count, output, 8 bits, the number of completed legal cycles.

Function
REQ-015 Lamp encodings {red,orange,green} SHALL be: RED=100, RED_ORANGE=110, GREEN=001, ORANGE=010; every other value is ILLEGAL.
REQ-016 The only legal phase order SHALL be RED->RED_ORANGE->GREEN->ORANGE->RED.
REQ-017 The FSM SHALL have two states: UNSYNC (phase_valid=0) and TRACK (phase_valid=1).
REQ-018 In UNSYNC, the FSM SHALL move to TRACK on the first sampled RED, setting phase=RED and dwell_cnt=1; that first RED dwell SHALL NOT be checked.
REQ-019 In TRACK, if the input equals the current phase: when dwell_cnt < DELAY(phase), dwell_cnt SHALL increment; otherwise DWELL_LONG SHALL be raised that cycle.
REQ-020 In TRACK, if the input is the legal successor: when dwell_cnt == DELAY(phase), the FSM SHALL advance phase with dwell_cnt=1; otherwise DWELL_SHORT SHALL be raised.
REQ-021 In TRACK, a legal but non-successor encoding SHALL raise BAD_ORDER, and an ILLEGAL encoding SHALL raise ILLEGAL_ENC; ILLEGAL_ENC SHALL take priority over every other error.
REQ-022 Error codes SHALL be: NONE=0, ILLEGAL_ENC=1, BAD_ORDER=2, DWELL_SHORT=3, DWELL_LONG=4.
REQ-023 On any error, err SHALL go to 1 and stay 1, err_code SHALL be loaded only if err was 0 (first error wins), and the FSM SHALL enter UNSYNC.
REQ-024 ILLEGAL encodings seen in UNSYNC SHALL NOT raise an error.
REQ-025 A legal ORANGE->RED advance SHALL pulse cycle_done for exactly 1 cycle and increment cycle_count, wrapping 255->0.
REQ-026 A cycle SHALL count only if every phase since the last RED entry was dwell-checked, so the first RED entry after sync does not count.
REQ-027 All outputs SHALL be registered; an input change at edge N SHALL be visible on the outputs after edge N, a latency of 1 clk.

Reset
REQ-028 Asserting rstn low SHALL immediately force state=UNSYNC, phase=RED (0), phase_valid=0, err=0, err_code=0, cycle_done=0, cycle_count=0 and dwell_cnt=0.
REQ-029 A reset asserted mid-cycle SHALL discard all partial dwell and cycle progress, and resync SHALL follow REQ-018.

Structure
REQ-030 A package traffic_pkg SHALL hold phase_t (RED=0, RED_ORANGE=1, GREEN=2, ORANGE=3), err_code_t, and a next_phase function.
REQ-031 One combinational sub-module, traffic_phase_decode, SHALL map {red,orange,green} to phase_t plus a legal flag.
REQ-032 The DELAY-per-phase selection and the dwell counter SHALL reside in traffic_light_monitor.

Verification
REQ-033 Reset, then a legal sequence of RED x4, RO x1, GREEN x6, ORANGE x1, repeated 3 times -> err=0, and cycle_done pulses twice (the first RED is not counted; the 3rd cycle's RED follows) with cycle_count=2 after the 3rd ORANGE->RED.
REQ-034 After sync, GREEN held for 7 cycles -> DWELL_LONG on the 7th sample, err_code=4, phase_valid=0.
REQ-035 After sync, RED held for 3 checked cycles then RO -> err_code=3; then feeding 111 -> err stays 1 and err_code stays 3.
REQ-036 After sync, RED x4 then GREEN -> err_code=2.
REQ-037 In TRACK, input 000 -> err_code=1; then RED -> phase_valid=1 again with err still 1.
REQ-038 Run 256 legal cycles -> cycle_count wraps to 0; assert rstn low mid-GREEN -> all outputs return to their reset values asynchronously.
